// File: rtl/platform_led_fader.sv
// PWM LED driver that turns on/off requests into saturating linear brightness ramps.
// Request is registered once; a free-running prescaler paces the ramp steps.
module platform_led_fader #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP     = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                led_req,
    output logic                led_out,
    output logic [PWM_BITS-1:0] level,
    output logic                busy
);

    localparam int unsigned         PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS:0]   LVL_MAX_W = {1'b0, LVL_MAX};
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(STEP);

    typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;

    state_t              state;
    logic                req_q;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic [PWM_BITS:0]   lvl_up;
    logic [PWM_BITS-1:0] up_sat;
    logic [PWM_BITS-1:0] dn_sat;

    assign tick   = (pre_cnt == PRE_LAST);
    // One extra bit of headroom so the upward step can be clamped instead of wrapping.
    assign lvl_up = {1'b0, level} + STEP_W;
    assign up_sat = (lvl_up >= LVL_MAX_W) ? LVL_MAX : lvl_up[PWM_BITS-1:0];
    assign dn_sat = ({1'b0, level} <= STEP_W) ? '0 : (level - PWM_BITS'(STEP));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= OFF;
            level   <= '0;
            led_out <= 1'b0;
            busy    <= 1'b0;
            pwm_cnt <= '0;
            pre_cnt <= '0;
            req_q   <= 1'b0;
        end else begin
            req_q   <= led_req;
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            led_out <= (level == LVL_MAX) | (pwm_cnt < level);

            // A direction change takes priority over a coincident tick.
            case (state)
                OFF: begin
                    if (req_q) begin
                        state <= RISE;
                        busy  <= 1'b1;
                    end
                end
                RISE: begin
                    if (!req_q) begin
                        state <= FALL;
                    end else if (tick) begin
                        level <= up_sat;
                        if (up_sat == LVL_MAX) begin
                            state <= ON;
                            busy  <= 1'b0;
                        end
                    end
                end
                ON: begin
                    if (!req_q) begin
                        state <= FALL;
                        busy  <= 1'b1;
                    end
                end
                FALL: begin
                    if (req_q) begin
                        state <= RISE;
                    end else if (tick) begin
                        level <= dn_sat;
                        if (dn_sat == '0) begin
                            state <= OFF;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= OFF;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_platform_led_fader.sv
// Directed bench for platform_led_fader: expected brightness sequences are queued as
// stimulus is applied and popped as each level change appears on the DUT.
module tb_platform_led_fader;

    logic       clk;
    logic       reset_n;
    logic       req_a, req_b, req_c;
    logic       out_a, out_b, out_c;
    logic       busy_a, busy_b, busy_c;
    logic [3:0] lvl_a, lvl_b, lvl_c;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [3:0]  exp_q[$];

    platform_led_fader #(.PRESCALE(4), .PWM_BITS(4), .STEP(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .led_req(req_a),
        .led_out(out_a), .level(lvl_a), .busy(busy_a));

    platform_led_fader #(.PRESCALE(1), .PWM_BITS(4), .STEP(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .led_req(req_b),
        .led_out(out_b), .level(lvl_b), .busy(busy_b));

    // Long prescale keeps each level constant across several full PWM windows.
    platform_led_fader #(.PRESCALE(40), .PWM_BITS(4), .STEP(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .led_req(req_c),
        .led_out(out_c), .level(lvl_c), .busy(busy_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cur_lvl(input int sel);
        case (sel)
            0:       return lvl_a;
            1:       return lvl_b;
            default: return lvl_c;
        endcase
    endfunction

    task automatic expect_levels(input int sel, input string tag);
        logic [3:0] e, v, prev;
        logic       ok;
        while (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            prev = cur_lvl(sel);
            v    = prev;
            ok   = 1'b0;
            for (int i = 0; i < 8 && !ok; i++) begin
                @(negedge clk);
                if (cur_lvl(sel) !== prev) begin
                    ok = 1'b1;
                    v  = cur_lvl(sel);
                end
            end
            check({tag, "_timeout"}, 32'(ok), 32'd1);
            check(tag, 32'(v), 32'(e));
        end
    endtask

    task automatic duty_window(input logic [3:0] l);
        logic        ok;
        int unsigned ones;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (lvl_c === l) ok = 1'b1;
        end
        check("duty_reach", 32'(ok), 32'd1);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (out_c === 1'b1) ones++;
        end
        check("duty_ones", ones, 32'(l));
        check("duty_level_hold", 32'(lvl_c), 32'(l));
    endtask

    initial begin
        int unsigned ones;
        reset_n = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        req_c   = 1'b0;

        // Reset and idle hold
        repeat (3) @(negedge clk);
        check("reset_state", 32'({out_a, busy_a, lvl_a}), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_hold", 32'({out_a, busy_a, lvl_a}), 32'd0);
        end

        // Fade in
        for (int i = 1; i <= 15; i++) exp_q.push_back(4'(i));
        req_a = 1'b1;
        @(negedge clk);
        check("busy_one_clk", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("busy_two_clk", 32'(busy_a), 32'd1);
        check("level_before_step", 32'(lvl_a), 32'd0);
        expect_levels(0, "fade_in");
        check("on_busy", 32'(busy_a), 32'd0);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_a === 1'b1) ones++;
        end
        check("on_led_const", ones, 32'd64);
        check("on_level_hold", 32'(lvl_a), 32'd15);

        // Full fade out
        for (int i = 14; i >= 0; i--) exp_q.push_back(4'(i));
        req_a = 1'b0;
        expect_levels(0, "fade_out");
        check("off_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("off_led", 32'(out_a), 32'd0);

        // Abort a rise at level 5
        for (int i = 1; i <= 5; i++) exp_q.push_back(4'(i));
        req_a = 1'b1;
        expect_levels(0, "abort_rise");
        req_a = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_level_kept", 32'(lvl_a), 32'd5);
        check("abort_busy", 32'(busy_a), 32'd1);
        for (int i = 4; i >= 0; i--) exp_q.push_back(4'(i));
        expect_levels(0, "abort_fall");
        check("abort_off_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("abort_off_led", 32'(out_a), 32'd0);

        // Duty cycle at constant level during a rise
        req_c = 1'b1;
        duty_window(4'd1);
        duty_window(4'd8);
        duty_window(4'd14);
        req_c = 1'b0;

        // Asynchronous reset in the middle of a rise
        for (int i = 1; i <= 9; i++) exp_q.push_back(4'(i));
        req_a = 1'b1;
        expect_levels(0, "pre_reset_rise");
        #2 reset_n = 1'b0;
        #1 check("async_reset", 32'({out_a, busy_a, lvl_a}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("restart_idle_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("restart_busy", 32'(busy_a), 32'd1);
        check("restart_level", 32'(lvl_a), 32'd0);
        for (int i = 1; i <= 3; i++) exp_q.push_back(4'(i));
        expect_levels(0, "restart_rise");

        // Saturating steps with STEP=4, PRESCALE=1
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd12);
        exp_q.push_back(4'd15);
        req_b = 1'b1;
        expect_levels(1, "sat_rise");
        check("sat_on_busy", 32'(busy_b), 32'd0);
        exp_q.push_back(4'd11);
        exp_q.push_back(4'd7);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd0);
        req_b = 1'b0;
        expect_levels(1, "sat_fall");
        check("sat_off_busy", 32'(busy_b), 32'd0);
        repeat (3) @(negedge clk);
        check("sat_off_hold", 32'(lvl_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
